// File: rtl/irq_controller.sv
// Prioritised N_IRQ-source interrupt controller: edge detect, mask, lowest-index
// arbitration, int/ack handshake and in-service tracking. Define IRQ_NESTING_EN for preemption.
module irq_controller #(
  parameter int                 N_IRQ      = 4,
  parameter int                 ID_W       = 2,
  parameter int                 VEC_W      = 16,
  parameter logic [VEC_W-1:0]   VEC_BASE   = 16'h0010,
  parameter int                 VEC_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             int_out,
  input  logic             ack,
  output logic [VEC_W-1:0] vector,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy,
  output logic [N_IRQ-1:0] pending,
  input  logic             eoi
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] irq_q;
  logic             armed;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] rise, eligible, clr, sel;
  logic [ID_W-1:0]  win_id, id_nxt;
  logic [VEC_W-1:0] vec_nxt;
  logic             int_nxt;
`ifdef IRQ_NESTING_EN
  logic [N_IRQ-1:0] serv, serv_nxt;
`else
  logic             serv, serv_nxt;
`endif

  function automatic logic [ID_W-1:0] lowest(input logic [N_IRQ-1:0] bits);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (bits[i]) idx = ID_W'(i);
    return idx;
  endfunction

  function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + VEC_W'(id) * VEC_W'(VEC_STRIDE);
  endfunction

  function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // The first edge after reset only samples irq_in, so lines held high through
  // reset release are not mistaken for fresh rising edges.
  assign rise     = armed ? (irq_in & ~irq_q) : '0;
  assign eligible = pending & ~mask;
  assign win_id   = lowest(eligible);
  assign sel      = onehot(irq_id);
  assign busy     = |serv;

  always_comb begin
    state_nxt = state;
    int_nxt   = int_out;
    id_nxt    = irq_id;
    vec_nxt   = vector;
    serv_nxt  = serv;
    clr       = '0;
    unique case (state)
      IDLE: begin
        if (|eligible) begin
          id_nxt    = win_id;
          vec_nxt   = vec_of(win_id);
          int_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          clr       = sel;
          int_nxt   = 1'b0;
          state_nxt = SERV;
`ifdef IRQ_NESTING_EN
          serv_nxt  = serv | sel;
`else
          serv_nxt  = 1'b1;
`endif
        end
      end
      SERV: begin
`ifdef IRQ_NESTING_EN
        // eoi retires the highest-priority in-service source and falls back to the next one.
        if (eoi) begin
          serv_nxt = serv & (serv - N_IRQ'(1));
          if (serv_nxt == '0) begin
            state_nxt = IDLE;
          end else begin
            id_nxt  = lowest(serv_nxt);
            vec_nxt = vec_of(id_nxt);
          end
        end else if ((|eligible) && (win_id < lowest(serv))) begin
          id_nxt    = win_id;
          vec_nxt   = vec_of(win_id);
          int_nxt   = 1'b1;
          state_nxt = REQ;
        end
`else
        if (eoi) begin
          serv_nxt  = 1'b0;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      irq_q   <= '0;
      armed   <= 1'b0;
      pending <= '0;
      mask    <= '0;
      int_out <= 1'b0;
      irq_id  <= '0;
      vector  <= '0;
      serv    <= '0;
    end else begin
      state   <= state_nxt;
      irq_q   <= irq_in;
      armed   <= 1'b1;
      // A new edge beats the ack-clear on the same source.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      int_out <= int_nxt;
      irq_id  <= id_nxt;
      vector  <= vec_nxt;
      serv    <= serv_nxt;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller (default, non-nested build): directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_irq_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_out;
  logic        ack;
  logic [15:0] vector;
  logic [1:0]  irq_id;
  logic        busy;
  logic [3:0]  pending;
  logic        eoi;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0]  m_pending, m_mask, m_prev;
  int          m_edges_seen;
  bit          m_int, m_busy;
  int          m_id;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_out    (int_out),
    .ack        (ack),
    .vector     (vector),
    .irq_id     (irq_id),
    .busy       (busy),
    .pending    (pending),
    .eoi        (eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [15:0] exp_vec(input int id);
    logic [15:0] v;
    v = 16'h0010 + 16'(id * 2);
    return v;
  endfunction

  task automatic model_reset();
    m_pending    = '0;
    m_mask       = '0;
    m_prev       = '0;
    m_edges_seen = 0;
    m_int        = 0;
    m_busy       = 0;
    m_id         = 0;
  endtask

  task automatic model_step();
    logic [3:0] newly;
    logic [3:0] served;
    logic [3:0] avail;
    newly  = '0;
    served = '0;
    avail  = m_pending & ~m_mask;
    for (int i = 0; i < 4; i++)
      if (m_edges_seen > 0 && irq_in[i] && !m_prev[i]) newly[i] = 1'b1;
    if (m_int) begin
      if (ack) begin
        served[m_id] = 1'b1;
        m_int  = 0;
        m_busy = 1;
      end
    end else if (m_busy) begin
      if (eoi) m_busy = 0;
    end else if (avail != 0) begin
      for (int i = 3; i >= 0; i--)
        if (avail[i]) m_id = i;
      m_int = 1;
    end
    m_pending = (m_pending & ~served) | newly;
    m_prev    = irq_in;
    if (mask_we) m_mask = mask_wdata;
    m_edges_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    model_reset();
    tick(); tick();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", int_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    checks++; if (vector !== 16'h0) begin errors++; $display("FAIL reset_vector: got %h want 0000", vector); end
    reset = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single();
    irq_in = 4'b0100; tick(); irq_in = '0;
    checks++; if (pending !== 4'b0100 || int_out !== 1'b0) begin errors++;
      $display("FAIL single_pending: got pending=%b int=%b want 0100/0", pending, int_out); end
    tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd2 || vector !== 16'h0014) begin errors++;
      $display("FAIL single_req: got int=%b id=%0d vec=%h want 1/2/0014", int_out, irq_id, vector); end
    pulse_ack();
    checks++; if (pending[2] !== 1'b0 || busy !== 1'b1 || int_out !== 1'b0) begin errors++;
      $display("FAIL single_ack: got pend2=%b busy=%b int=%b want 0/1/0", pending[2], busy, int_out); end
    pulse_eoi();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_eoi: got busy=%b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd1 || vector !== 16'h0012) begin errors++;
      $display("FAIL simul_first: got int=%b id=%0d vec=%h want 1/1/0012", int_out, irq_id, vector); end
    pulse_ack(); pulse_eoi(); tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd3 || vector !== 16'h0016) begin errors++;
      $display("FAIL simul_second: got int=%b id=%0d vec=%h want 1/3/0016", int_out, irq_id, vector); end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_mask();
    int seen_int;
    seen_int = 0;
    mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = '0;
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL mask_pending: got %b want 1", pending[0]); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_out !== 1'b0) seen_int++;
    end
    checks++; if (seen_int != 0) begin errors++; $display("FAIL mask_blocks: int_out high in %0d of 10 cycles, want 0", seen_int); end
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL mask_old_used: got int=%b want 0", int_out); end
    tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd0) begin errors++;
      $display("FAIL mask_release: got int=%b id=%0d want 1/0", int_out, irq_id); end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_commit();
    irq_in = 4'b1000; tick(); irq_in = '0; tick();
    irq_in = 4'b0010; tick(); irq_in = '0;
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd3) begin errors++;
      $display("FAIL commit_hold1: got int=%b id=%0d want 1/3", int_out, irq_id); end
    tick();
    checks++; if (irq_id !== 2'd3 || vector !== 16'h0016) begin errors++;
      $display("FAIL commit_hold2: got id=%0d vec=%h want 3/0016", irq_id, vector); end
    pulse_ack(); pulse_eoi(); tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd1) begin errors++;
      $display("FAIL commit_next: got int=%b id=%0d want 1/1", int_out, irq_id); end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_async_reset();
    int bad;
    bad = 0;
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    pulse_ack();
    irq_in = 4'b0001; tick(); irq_in = '0;
    checks++; if (busy !== 1'b1 || pending !== 4'b0001) begin errors++;
      $display("FAIL areset_setup: got busy=%b pending=%b want 1/0001", busy, pending); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (int_out !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin errors++;
      $display("FAIL areset_immediate: got int=%b busy=%b pending=%b want 0/0/0000", int_out, busy, pending); end
    irq_in = 4'b1111;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (int_out !== 1'b0 || pending !== 4'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL areset_held_high: %0d of 5 cycles showed a request, want 0", bad); end
    irq_in = '0; tick();
    irq_in = 4'b0001; tick(); irq_in = '0; tick();
    checks++; if (int_out !== 1'b1 || irq_id !== 2'd0) begin errors++;
      $display("FAIL areset_fresh_edge: got int=%b id=%0d want 1/0", int_out, irq_id); end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      irq_in     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      ack        = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 4'($urandom) & 4'($urandom);
      tick();
      checks++; if (int_out !== m_int) begin errors++;
        $display("FAIL rand_int_out[%0d]: got %b want %b", n, int_out, m_int); end
      checks++; if (busy !== m_busy) begin errors++;
        $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, m_busy); end
      checks++; if (pending !== m_pending) begin errors++;
        $display("FAIL rand_pending[%0d]: got %b want %b", n, pending, m_pending); end
      if (m_int || m_busy) begin
        checks++; if (irq_id !== 2'(m_id)) begin errors++;
          $display("FAIL rand_irq_id[%0d]: got %0d want %0d", n, irq_id, m_id); end
      end
      if (m_int) begin
        checks++; if (vector !== exp_vec(m_id)) begin errors++;
          $display("FAIL rand_vector[%0d]: got %h want %h", n, vector, exp_vec(m_id)); end
      end
    end
    irq_in = '0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_commit();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Multi-channel interrupt controller that generalises the processor's single int/ack pair to N_IRQ prioritised sources.
- Detects rising edges on the source lines, latches them as pending, and applies a mask register.
- Presents the highest-priority (lowest-index) request to the pipeline on int_out, together with its ISR vector.
- Tracks the in-service interrupt until the processor signals end-of-interrupt (RTI retire).

Parameters:
N_IRQ, 4, number of interrupt sources; legal range 2..16
ID_W, 2, width of irq_id; must equal $clog2(N_IRQ)
VEC_W, 16, vector/address width; matches the processor data width
VEC_BASE, 16'h0010, vector of source 0
VEC_STRIDE, 2, address step between consecutive source vectors

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
irq_in  in  N_IRQ  raw interrupt sources; rising-edge sensitive
mask_we  in  1  mask register write strobe
mask_wdata  in  N_IRQ  new mask value; bit=1 disables that source
int_out  out  1  interrupt request to the processor int input
ack  in  1  one-cycle processor acknowledge of int_out
vector  out  VEC_W  ISR address; valid while int_out=1
irq_id  out  ID_W  index of the requested/in-service source
busy  out  1  an interrupt is in service
pending  out  N_IRQ  pending register, readable for debug
eoi  in  1  one-cycle end-of-interrupt pulse

Behaviour:
- Reset (reset=0, asynchronous): irq_q, pending, mask, int_out, vector, irq_id and busy all 0; state IDLE. Reset mid-operation drops any request or in-service interrupt immediately.
- Edge detect:
  - irq_q <= irq_in every cycle.
  - pending[i] is set at the edge where irq_in[i]=1 and irq_q[i]=0.
  - Held-high sources do not re-trigger.
- Mask:
  - mask <= mask_wdata when mask_we=1.
  - Masked bits stay pending but are never selected; unmasking later makes them eligible.
- Selection: eligible = pending & ~mask. The winner is the lowest set index.
- Vector: vector = VEC_BASE + irq_id*VEC_STRIDE, computed modulo 2^VEC_W (wrap allowed).
- FSM:
  - IDLE: if eligible is non-zero, latch the winner into irq_id and vector, assert int_out, go to REQ. Otherwise stay.
  - REQ: int_out=1 and irq_id/vector are held stable. The request is committed: a later mask write or a new higher-priority edge does not change it.
    - On ack=1: clear pending[irq_id], int_out=0, busy=1, go to SERV.
  - SERV: busy=1, irq_id holds the in-service source.
    - On eoi=1: busy=0, go to IDLE. A new request may assert on the following edge.
- Latency: irq_in rises before edge k → pending set at k → int_out=1 after edge k+1 (2 cycles), if the FSM is in IDLE and the source is unmasked.
- Simultaneous events:
  - A new edge on source j in the same cycle that ack clears pending[j]: set wins, and j remains pending.
  - mask_we in the same cycle as selection: the old mask is used for that cycle.
- Ignored inputs: ack outside REQ; eoi outside SERV (non-nested build).

Optional Feature:
- Macro: IRQ_NESTING_EN.
- With the macro defined:
  - An N_IRQ-bit in_service vector replaces the single busy flag.
  - In SERV, an eligible source with index lower than the lowest set in_service bit raises a new REQ (preemption); on its ack, that in_service bit is set.
  - eoi clears the lowest set in_service bit, and irq_id reverts to the next lowest set bit.
  - busy = |in_service; the FSM returns to IDLE when in_service becomes 0.
- Without the macro: no preemption; eligible sources wait in pending until eoi.

Test Plan:
- Reset, then pulse irq_in=4'b0100 → int_out=1 two cycles later, irq_id=2, vector=16'h0014. Assert ack → pending[2]=0, busy=1. Assert eoi → busy=0.
- Set irq_in=4'b1010 in the same cycle → irq_id=1, vector=16'h0012 first. After ack+eoi, source 3 is served with vector=16'h0016.
- Write mask=4'b0001, then pulse irq0 → pending[0]=1 and int_out stays 0 for 10 cycles. Write mask=0 → int_out=1 two cycles later, irq_id=0.
- In REQ for source 3, pulse irq1 → irq_id stays 3 until ack. After eoi, source 1 is requested.
- Pull reset low while busy=1 → int_out, busy and pending read 0 immediately, without waiting for a clock edge. Hold irq_in=4'b1111 high through reset release → no new request until a fresh rising edge.
- IRQ_NESTING_EN: source 2 in service, pulse irq0 → int_out reasserts with irq_id=0 and in_service=4'b0101 after ack. First eoi → irq_id=2 and busy=1. Second eoi → busy=0.
